// File: rtl/pheader_packer_if.sv
// Bundles the header input, payload input and packed output streams of the
// telemetry packetiser. The "master" side drives headers, payload beats and
// downstream ready. The "slave" side is the packer itself.
interface pheader_packer_if #(
  parameter int CNT_W = 16
);
  logic [47:0]      header_in;
  logic             header_valid;
  logic             header_ready;
  logic [31:0]      payload_in;
  logic             payload_valid;
  logic             payload_last;
  logic             payload_ready;
  logic [31:0]      data_out;
  logic             valid_out;
  logic             ready_out;
  logic             sop_out;
  logic             eop_out;
  logic             overflow_err;
  logic [CNT_W-1:0] pkt_count;

  modport master (
    output header_in, header_valid, payload_in, payload_valid, payload_last, ready_out,
    input  header_ready, payload_ready, data_out, valid_out, sop_out, eop_out,
    input  overflow_err, pkt_count
  );

  modport slave (
    input  header_in, header_valid, payload_in, payload_valid, payload_last, ready_out,
    output header_ready, payload_ready, data_out, valid_out, sop_out, eop_out,
    output overflow_err, pkt_count
  );
endinterface

// File: rtl/pheader_packer.sv
// Transmit-side packetiser. It packs a 48-bit header and a stream of 32-bit
// payload beats into a 32-bit word stream:
//   word0 = header[47:16]
//   word1 = {header[15:0], first_beat[15:0]}
//   word2 onwards = full payload beats
// A single output register holds each word. Upstream ready signals are
// combinational from the state and from whether that register can take a word.
// A packet longer than MAX_BEATS is cut short. Its last kept word carries eop,
// and the remaining beats are swallowed.
module pheader_packer #(
  parameter int MAX_BEATS = 256,
  parameter int CNT_W     = 16
) (
  input  logic            clk,
  input  logic            reset,
  pheader_packer_if.slave bus
);

  localparam int BC_W = $clog2(MAX_BEATS + 1);
  localparam logic [BC_W-1:0] LAST_CNT = BC_W'(MAX_BEATS - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FIRST = 2'd1;
  localparam logic [1:0] BODY  = 2'd2;
  localparam logic [1:0] DROP  = 2'd3;

  logic [1:0]       state_reg, state_next;
  logic [BC_W-1:0]  beat_cnt_reg;
  logic [15:0]      hdr_lo_reg;
  logic [31:0]      data_reg, data_next;
  logic             valid_reg, sop_reg, eop_reg, ovf_reg;
  logic             sop_next, eop_next;
  logic [CNT_W-1:0] pkt_count_reg;

  logic out_free, in_payload, hdr_acc, beat_acc, load, trunc;

  assign out_free   = !valid_reg || bus.ready_out;
  assign in_payload = (state_reg == FIRST) || (state_reg == BODY);

  assign bus.header_ready  = (state_reg == IDLE) && out_free;
  // DROP always accepts, because discarded beats never need the output register.
  assign bus.payload_ready = in_payload ? out_free : (state_reg == DROP);

  assign hdr_acc  = bus.header_valid && bus.header_ready;
  assign beat_acc = bus.payload_valid && bus.payload_ready;
  assign trunc    = beat_acc && in_payload && (beat_cnt_reg == LAST_CNT) && !bus.payload_last;
  assign load     = hdr_acc || (beat_acc && in_payload);

  assign bus.data_out     = data_reg;
  assign bus.valid_out    = valid_reg;
  assign bus.sop_out      = sop_reg;
  assign bus.eop_out      = eop_reg;
  assign bus.overflow_err = ovf_reg;
  assign bus.pkt_count    = pkt_count_reg;

  // Next-state and next-output-word selection.
  always_comb begin
    state_next = state_reg;
    data_next  = data_reg;
    sop_next   = sop_reg;
    eop_next   = eop_reg;
    case (state_reg)
      IDLE: begin
        if (hdr_acc) begin
          data_next  = bus.header_in[47:16];
          sop_next   = 1'b1;
          eop_next   = 1'b0;
          state_next = FIRST;
        end
      end
      FIRST, BODY: begin
        if (beat_acc) begin
          // Only the low half of the first beat fits beside the header tail.
          data_next  = (state_reg == FIRST) ? {hdr_lo_reg, bus.payload_in[15:0]}
                                            : bus.payload_in;
          sop_next   = 1'b0;
          eop_next   = bus.payload_last || trunc;
          state_next = bus.payload_last ? IDLE : (trunc ? DROP : BODY);
        end
      end
      DROP: begin
        if (beat_acc && bus.payload_last) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, beat counter and latched header tail.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      beat_cnt_reg <= '0;
      hdr_lo_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (hdr_acc) begin
        hdr_lo_reg   <= bus.header_in[15:0];
        beat_cnt_reg <= '0;
      end else if (beat_acc && in_payload) begin
        beat_cnt_reg <= beat_cnt_reg + BC_W'(1);
      end
    end
  end

  // Output register. It holds while stalled and empties on consume with no reload.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_reg      <= '0;
      valid_reg     <= 1'b0;
      sop_reg       <= 1'b0;
      eop_reg       <= 1'b0;
      ovf_reg       <= 1'b0;
      pkt_count_reg <= '0;
    end else begin
      ovf_reg <= trunc;
      if (load) begin
        data_reg  <= data_next;
        sop_reg   <= sop_next;
        eop_reg   <= eop_next;
        valid_reg <= 1'b1;
        if (eop_next) begin
          pkt_count_reg <= pkt_count_reg + CNT_W'(1);
        end
      end else if (bus.ready_out) begin
        valid_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pheader_packer.sv
// Directed bench for pheader_packer. The drivers push the expected output words
// into a scoreboard queue as each input is accepted. A monitor pops and compares
// them as the downstream side consumes each word.
module tb_pheader_packer;

  localparam int MAXB = 4;
  localparam int CW   = 8;

  typedef struct {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic        ovf;
  } exp_t;

  logic   clk = 1'b0;
  logic   reset = 1'b0;
  longint cyc = 0;

  exp_t          sb[$];
  int            checks = 0;
  int            passed = 0;
  int            fails  = 0;
  logic [15:0]   m_hlo  = '0;
  int            m_idx  = 0;
  logic [CW-1:0] m_pkts = '0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  pheader_packer_if #(.CNT_W(CW)) bus ();

  pheader_packer #(.MAX_BEATS(MAXB), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Present one header and hold it until accepted; queue the expected word0.
  task automatic send_hdr(input logic [47:0] h);
    int   n;
    logic ok;
    n  = 0;
    ok = 1'b0;
    bus.header_in    = h;
    bus.header_valid = 1'b1;
    while (!ok && n < 100) begin
      @(negedge clk);
      ok = bus.header_ready;
      n++;
      if (ok) sb.push_back('{h[47:16], 1'b1, 1'b0, 1'b0});
      @(posedge clk);
      #1;
    end
    checks++;
    assert (ok) passed++;
    else begin
      fails++;
      $error("FAIL hdr_timeout observed=not_accepted expected=accepted");
    end
    bus.header_valid = 1'b0;
    m_hlo = h[15:0];
    m_idx = 0;
  endtask

  // Present one beat until accepted; queue the word the packer should emit for it.
  task automatic send_beat(input logic [31:0] b, input logic last);
    int   n;
    logic ok;
    logic tr;
    exp_t e;
    n  = 0;
    ok = 1'b0;
    bus.payload_in    = b;
    bus.payload_last  = last;
    bus.payload_valid = 1'b1;
    while (!ok && n < 100) begin
      @(negedge clk);
      ok = bus.payload_ready;
      n++;
      if (ok && m_idx < MAXB) begin
        tr     = (m_idx == MAXB - 1) && !last;
        e.data = (m_idx == 0) ? {m_hlo, b[15:0]} : b;
        e.sop  = 1'b0;
        e.eop  = last || tr;
        e.ovf  = tr;
        sb.push_back(e);
        if (e.eop) m_pkts = m_pkts + 1'b1;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    assert (ok) passed++;
    else begin
      fails++;
      $error("FAIL beat_timeout observed=not_accepted expected=accepted");
    end
    bus.payload_valid = 1'b0;
    bus.payload_last  = 1'b0;
    m_idx++;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_left", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: compare each consumed word against the head of the scoreboard.
  initial begin : monitor
    exp_t e;
    logic seen_ovf;
    seen_ovf = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        seen_ovf = 1'b0;
      end else begin
        seen_ovf = seen_ovf | bus.overflow_err;
        if (bus.valid_out && bus.ready_out) begin
          checks++;
          assert (sb.size() != 0) passed++;
          else begin
            fails++;
            $error("FAIL unexpected_word observed=0x%08h expected=none", bus.data_out);
          end
          if (sb.size() != 0) begin
            e = sb.pop_front();
            $display("word data=%08h sop=%0b eop=%0b ovf=%0b exp=%08h", bus.data_out,
                     bus.sop_out, bus.eop_out, seen_ovf, e.data);
            chk("word_data", bus.data_out, e.data);
            chk("word_sop", 32'(bus.sop_out), 32'(e.sop));
            chk("word_eop", 32'(bus.eop_out), 32'(e.eop));
            chk("word_ovf", 32'(seen_ovf), 32'(e.ovf));
          end
          seen_ovf = 1'b0;
        end
      end
    end
  end

  initial begin : stim
    longint start_cyc;
    bus.header_in     = '0;
    bus.header_valid  = 1'b0;
    bus.payload_in    = '0;
    bus.payload_valid = 1'b0;
    bus.payload_last  = 1'b0;
    bus.ready_out     = 1'b1;

    // Reset takes effect before the first clock edge.
    #1 reset = 1'b1;
    #2;
    chk("rst_valid", 32'(bus.valid_out), 32'd0);
    chk("rst_data", bus.data_out, 32'd0);
    chk("rst_sop", 32'(bus.sop_out), 32'd0);
    chk("rst_eop", 32'(bus.eop_out), 32'd0);
    chk("rst_pkt_count", 32'(bus.pkt_count), 32'd0);
    chk("rst_payload_ready", 32'(bus.payload_ready), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1;

    // Two-beat packet.
    send_hdr(48'h112233445566);
    send_beat(32'hAAAABBBB, 1'b0);
    send_beat(32'hCCCCDDDD, 1'b1);
    drain();
    chk("t1_pkt_count", 32'(bus.pkt_count), 32'd1);

    // Single-beat packet: word1 carries eop.
    send_hdr(48'hA5A5A5A51234);
    send_beat(32'h0000F00D, 1'b1);
    drain();
    chk("t2_pkt_count", 32'(bus.pkt_count), 32'd2);

    // Downstream stall while word1 is pending.
    send_hdr(48'h010203040506);
    send_beat(32'h11112222, 1'b0);
    bus.ready_out     = 1'b0;
    bus.payload_in    = 32'h33334444;
    bus.payload_last  = 1'b1;
    bus.payload_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stall_data", bus.data_out, 32'h05062222);
      chk("stall_valid", 32'(bus.valid_out), 32'd1);
      chk("stall_payload_ready", 32'(bus.payload_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    bus.ready_out = 1'b1;
    send_beat(32'h33334444, 1'b1);
    drain();
    chk("t3_pkt_count", 32'(bus.pkt_count), 32'(m_pkts));

    // Six beats into a four-beat limit: truncation, then two dropped beats.
    send_hdr(48'hCAFE00000001);
    for (int i = 1; i <= 6; i++) send_beat(32'h10000000 + 32'(i), i == 6);
    drain();
    chk("t4_pkt_count", 32'(bus.pkt_count), 32'd4);
    chk("t4_ovf_idle", 32'(bus.overflow_err), 32'd0);

    // Reset in the middle of the packet body.
    send_hdr(48'hDEADBEEF0001);
    send_beat(32'h01010101, 1'b0);
    send_beat(32'h02020202, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("arst_valid", 32'(bus.valid_out), 32'd0);
    chk("arst_data", bus.data_out, 32'd0);
    chk("arst_sop", 32'(bus.sop_out), 32'd0);
    chk("arst_eop", 32'(bus.eop_out), 32'd0);
    chk("arst_ovf", 32'(bus.overflow_err), 32'd0);
    chk("arst_pkt_count", 32'(bus.pkt_count), 32'd0);
    sb.delete();
    m_pkts = '0;
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1;
    send_hdr(48'h5A5A5A5A0F0F);
    send_beat(32'h12345678, 1'b1);
    drain();
    chk("t5_pkt_count", 32'(bus.pkt_count), 32'd1);

    // Back-to-back two-beat packets across the counter wrap.
    start_cyc = cyc;
    for (int i = 0; i < 254; i++) begin
      send_hdr({16'h0, 32'(i)});
      send_beat(32'h0000AB00 + 32'(i), 1'b0);
      send_beat(32'h00CD0000 + 32'(i), 1'b1);
    end
    chk("t6_pkt_count_full", 32'(bus.pkt_count), 32'h000000FF);
    send_hdr(48'hFFFF00000000);
    send_beat(32'h0BAD0BAD, 1'b0);
    send_beat(32'h600D600D, 1'b1);
    chk("t6_pkt_count_wrap", 32'(bus.pkt_count), 32'd0);
    chk("t6_cycles", 32'(cyc - start_cyc), 32'd765);
    drain();
    chk("t6_pkt_count_model", 32'(bus.pkt_count), 32'(m_pkts));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
